adc_trigger_capture: RTL

Trigger and capture stage directly downstream of the ADC sampling block in the scope design. Consumes the registered 8-bit ADC sample stream and continuously records it into a circular block-RAM buffer once armed. On a level-crossing trigger it keeps a fixed number of pre-trigger samples and fills the rest with post-trigger samples. It then freezes the buffer and hands it out sample-by-sample, oldest first, through a simple request/valid read port to the readout/transport logic.

---
 rtl/adc_trigger_capture.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_trigger_capture.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_trigger_capture
//
// Trigger/capture stage behind the ADC sampling block. Once armed, it records
// the 8-bit sample stream into a circular block-RAM buffer. On a level-crossing
// trigger (or a forced trigger) it keeps PRETRIG pre-trigger samples and fills
// the rest of the buffer with post-trigger samples. It then freezes the buffer
// and plays it back oldest first through a request/valid read port.
//
// Parameters
//   DEPTH_LOG2    buffer depth is 2**DEPTH_LOG2 samples
//   PRETRIG       pre-trigger samples kept (1 .. 2**DEPTH_LOG2-1)
//
// Ports
//   iCLK          system clock, rising edge
//   iRST_N        asynchronous active-low reset
//   iSample       unsigned ADC sample
//   iSampleValid  iSample is a new sample this cycle
//   iArm          pulse: start acquisition (IDLE, or DONE to discard buffer)
//   iLevel        trigger threshold, unsigned
//   iFalling      0 = rising-edge trigger, 1 = falling-edge trigger
//   iForce        pulse: force a trigger on the next valid sample (WAIT_TRIG)
//   oArmed        high in PRE and WAIT_TRIG
//   oTriggered    high in POST
//   oDone         high in DONE and READ (buffer frozen, readable)
//   iRdReq        request next sample
//   oRdData       read sample (one cycle after the request)
//   oRdValid      oRdData valid this cycle
//   oRdLast       with oRdValid, marks the final sample of the buffer
// -----------------------------------------------------------------------------
module adc_trigger_capture #(
  parameter int DEPTH_LOG2 = 9,
  parameter int PRETRIG    = 128
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iSample,
  input  logic       iSampleValid,
  input  logic       iArm,
  input  logic [7:0] iLevel,
  input  logic       iFalling,
  input  logic       iForce,
  output logic       oArmed,
  output logic       oTriggered,
  output logic       oDone,
  input  logic       iRdReq,
  output logic [7:0] oRdData,
  output logic       oRdValid,
  output logic       oRdLast
);

  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int POST_LEN = DEPTH - PRETRIG;   // includes the trigger sample

  localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRETRIG - 1);
  localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_LEN - 1);
  localparam logic [DEPTH_LOG2-1:0] RD_LAST   = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] PRE_OFS   = DEPTH_LOG2'(PRETRIG);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  // With PRETRIG = DEPTH-1 the trigger sample alone completes the buffer.
  localparam bit                    POST_ONE  = (POST_LEN == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE,
    S_READ
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_pre_cnt;
  logic [DEPTH_LOG2-1:0] r_post_cnt;
  logic [DEPTH_LOG2-1:0] r_trig_addr;
  logic [DEPTH_LOG2-1:0] r_rd_cnt;
  logic [7:0]            r_prev;
  logic                  r_prev_ok;     // r_prev holds a sample from this acquisition
  logic                  r_force_pend;  // iForce seen, waiting for a valid sample
  logic [7:0]            r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_last;
  logic                  r_armed;
  logic                  r_triggered;
  logic                  r_done;

  // NOTE: the sample buffer has no reset; its contents are meaningless until
  // rewritten by an acquisition, and a reset would stop it mapping to block RAM.
  logic [7:0] r_mem [DEPTH];

  logic                  w_wr_en;
  logic                  w_arm_ok;
  logic                  w_rd_issue;
  logic                  w_rd_final;
  logic                  w_cross;
  logic                  w_trig;
  logic [DEPTH_LOG2-1:0] w_rd_addr;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign w_wr_en  = iSampleValid &&
                    (r_state == S_PRE || r_state == S_WAIT_TRIG || r_state == S_POST);

  // Arm restarts only from IDLE or an untouched frozen buffer (DONE).
  assign w_arm_ok = iArm && (r_state == S_IDLE || r_state == S_DONE);

  // Arm in DONE takes priority over a simultaneous read request.
  assign w_rd_issue = iRdReq && !w_arm_ok &&
                      (r_state == S_DONE || r_state == S_READ);
  assign w_rd_final = w_rd_issue && (r_rd_cnt == RD_LAST);

  // Oldest sample sits PRETRIG slots before the trigger sample.
  assign w_rd_addr = r_trig_addr - PRE_OFS + r_rd_cnt;

  assign w_cross = iFalling ? (r_prev >= iLevel && iSample <  iLevel)
                            : (r_prev <  iLevel && iSample >= iLevel);

  assign w_trig = (r_state == S_WAIT_TRIG) && iSampleValid &&
                  ((r_prev_ok && w_cross) || r_force_pend || iForce);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch
    // is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_arm_ok) w_next = S_PRE;
      end
      S_PRE: begin
        if (w_wr_en && r_pre_cnt == PRE_LAST) w_next = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: begin
        if (w_trig) w_next = POST_ONE ? S_DONE : S_POST;
      end
      S_POST: begin
        if (w_wr_en && r_post_cnt == POST_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        if (w_arm_ok)        w_next = S_PRE;
        else if (w_rd_issue) w_next = w_rd_final ? S_IDLE : S_READ;
      end
      S_READ: begin
        if (w_rd_final) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write side: pointers, counters, trigger bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wr_ptr     <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_trig_addr  <= '0;
      r_prev       <= '0;
      r_prev_ok    <= 1'b0;
      r_force_pend <= 1'b0;
    end else if (w_arm_ok) begin
      r_wr_ptr     <= '0;
      r_pre_cnt    <= '0;
      r_prev_ok    <= 1'b0;
      r_force_pend <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_wr_en && (r_state == S_PRE || r_state == S_WAIT_TRIG)) begin
        r_prev    <= iSample;
        r_prev_ok <= 1'b1;
      end
      if (w_wr_en && r_state == S_PRE) begin
        r_pre_cnt <= r_pre_cnt + PTR_ONE;
      end
      if (r_state == S_WAIT_TRIG) begin
        if (w_trig) begin
          r_trig_addr  <= r_wr_ptr;
          r_post_cnt   <= PTR_ONE;
          r_force_pend <= 1'b0;
        end else if (iForce) begin
          r_force_pend <= 1'b1;
        end
      end
      if (w_wr_en && r_state == S_POST) begin
        r_post_cnt <= r_post_cnt + PTR_ONE;
      end
    end
  end

  // Sample buffer write port.
  always_ff @(posedge iCLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= iSample;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_rd_cnt   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_issue;
      r_rd_last  <= w_rd_final;
      if (w_rd_issue) begin
        r_rd_data <= r_mem[w_rd_addr];
        r_rd_cnt  <= r_rd_cnt + PTR_ONE;
      end else if (w_next == S_DONE && r_state != S_DONE) begin
        r_rd_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered status outputs, decoded from the next state
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_armed     <= (w_next == S_PRE)  || (w_next == S_WAIT_TRIG);
      r_triggered <= (w_next == S_POST);
      r_done      <= (w_next == S_DONE) || (w_next == S_READ);
    end
  end

  assign oArmed     = r_armed;
  assign oTriggered = r_triggered;
  assign oDone      = r_done;
  assign oRdData    = r_rd_data;
  assign oRdValid   = r_rd_valid;
  assign oRdLast    = r_rd_last;

endmodule
